// File: rtl/rtc_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rtc_write_sequencer
// Brief   : Writes masked BCD time/timer fields to the RTC over a muxed A/D bus.
// Revision: 1.0 - initial release
// ============================================================================
module rtc_write_sequencer #(
    parameter int STROBE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] field_mask,
    input  logic [7:0] in_seg,
    input  logic [7:0] in_min,
    input  logic [7:0] in_hora,
    input  logic [7:0] in_dia,
    input  logic [7:0] in_mes,
    input  logic [7:0] in_anio,
    input  logic [7:0] in_seg_tim,
    input  logic [7:0] in_min_tim,
    input  logic [7:0] in_hora_tim,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_A_SETUP = 4'd1,
        S_A_STB   = 4'd2,
        S_A_HOLD  = 4'd3,
        S_D_SETUP = 4'd4,
        S_D_STB   = 4'd5,
        S_D_HOLD  = 4'd6,
        S_GAP     = 4'd7,
        S_FIN     = 4'd8
    } state_t;

    localparam logic [3:0] c_stb_load = 4'(STROBE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] mask_q;
    logic [7:0] vals_q [9];

    logic       w_accept;
    logic [4:0] w_first;
    logic [4:0] w_next;
    logic [7:0] w_addr;

    // Lowest set bit of m at or above index 'from'; bit 4 of the result flags a hit.
    function automatic logic [4:0] f_find(input logic [8:0] m, input logic [3:0] from);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 8; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_FIN));
    assign w_first  = f_find(field_mask, 4'd0);
    assign w_next   = f_find(mask_q, idx_q + 4'd1);

    always_comb begin
        w_addr = 8'h00;
        case (idx_q)
            4'd0:    w_addr = 8'h21;
            4'd1:    w_addr = 8'h22;
            4'd2:    w_addr = 8'h23;
            4'd3:    w_addr = 8'h24;
            4'd4:    w_addr = 8'h25;
            4'd5:    w_addr = 8'h26;
            4'd6:    w_addr = 8'h41;
            4'd7:    w_addr = 8'h42;
            4'd8:    w_addr = 8'h43;
            default: w_addr = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            mask_q  <= 9'd0;
            for (int i = 0; i < 9; i++) begin
                vals_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                mask_q    <= field_mask;
                vals_q[0] <= in_seg;
                vals_q[1] <= in_min;
                vals_q[2] <= in_hora;
                vals_q[3] <= in_dia;
                vals_q[4] <= in_mes;
                vals_q[5] <= in_anio;
                vals_q[6] <= in_seg_tim;
                vals_q[7] <= in_min_tim;
                vals_q[8] <= in_hora_tim;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ad_out  = 8'h00;
        ad_oe   = 1'b0;
        cs_n    = 1'b1;
        ad_n    = 1'b1;
        wr_n    = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE, S_FIN: begin
                done    = (state_q == S_FIN);
                state_d = S_IDLE;
                if (w_accept) begin
                    if (w_first[4]) begin
                        state_d = S_A_SETUP;
                        idx_d   = w_first[3:0];
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_A_SETUP, S_A_STB, S_A_HOLD, S_D_SETUP, S_D_STB, S_D_HOLD: begin
                busy  = 1'b1;
                cs_n  = 1'b0;
                ad_oe = 1'b1;
                if ((state_q == S_A_SETUP) || (state_q == S_A_STB) || (state_q == S_A_HOLD)) begin
                    ad_n   = 1'b0;
                    ad_out = w_addr;
                end else begin
                    ad_n   = 1'b1;
                    ad_out = vals_q[idx_q];
                end
                case (state_q)
                    S_A_SETUP: begin
                        state_d = S_A_STB;
                        cnt_d   = c_stb_load;
                    end
                    S_D_SETUP: begin
                        state_d = S_D_STB;
                        cnt_d   = c_stb_load;
                    end
                    S_A_STB, S_D_STB: begin
                        wr_n = 1'b0;
                        if (cnt_q == 4'd0) begin
                            state_d = (state_q == S_A_STB) ? S_A_HOLD : S_D_HOLD;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    S_A_HOLD: state_d = S_D_SETUP;
                    default:  state_d = S_GAP;
                endcase
            end
            S_GAP: begin
                busy = 1'b1;
                if (w_next[4]) begin
                    state_d = S_A_SETUP;
                    idx_d   = w_next[3:0];
                end else begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rtc_write_sequencer
// Brief   : Trace-model bench for rtc_write_sequencer, directed plus random.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rtc_write_sequencer;

    localparam int S = 4;

    typedef struct packed {
        logic [7:0] ad;
        logic       oe;
        logic       cs_n;
        logic       ad_n;
        logic       wr_n;
        logic       busy;
        logic       done;
    } obs_t;

    localparam obs_t c_idle = '{ad: 8'h00, oe: 1'b0, cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, busy: 1'b0, done: 1'b0};

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] field_mask;
    logic [7:0] v [9];
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, ad_n, wr_n, busy, done;

    logic [7:0] addr_tbl [9];
    int         n_checks = 0;
    int         n_fail   = 0;

    obs_t       q_exp [$];
    obs_t       exp_o, act_o;
    logic       acc;

    int         busy_cnt, done_cnt, cs_low_cnt, run;
    logic [7:0] addr_q [$];
    logic [7:0] data_q [$];
    int         runs [$];
    logic       prev_wr;
    int         clr_seq = 0;
    int         seen_seq = 0;

    rtc_write_sequencer #(.STROBE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .field_mask  (field_mask),
        .in_seg      (v[0]),
        .in_min      (v[1]),
        .in_hora     (v[2]),
        .in_dia      (v[3]),
        .in_mes      (v[4]),
        .in_anio     (v[5]),
        .in_seg_tim  (v[6]),
        .in_min_tim  (v[7]),
        .in_hora_tim (v[8]),
        .ad_out      (ad_out),
        .ad_oe       (ad_oe),
        .cs_n        (cs_n),
        .ad_n        (ad_n),
        .wr_n        (wr_n),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic [7:0] ad, input logic drive, input logic an,
                                input logic wr, input logic bsy, input logic dn);
        obs_t o;
        o.ad   = ad;
        o.oe   = drive;
        o.cs_n = ~drive;
        o.ad_n = an;
        o.wr_n = wr;
        o.busy = bsy;
        o.done = dn;
        return o;
    endfunction

    // Expected cycle-by-cycle bus trace of a whole burst from the captured snapshot.
    task automatic push_burst(input logic [8:0] m);
        logic [7:0] b;
        for (int f = 0; f < 9; f++) begin
            if (m[f]) begin
                for (int ph = 0; ph < 2; ph++) begin
                    b = (ph == 1) ? v[f] : addr_tbl[f];
                    q_exp.push_back(mk(b, 1'b1, ph[0], 1'b1, 1'b1, 1'b0));
                    for (int k = 0; k < S; k++) q_exp.push_back(mk(b, 1'b1, ph[0], 1'b0, 1'b1, 1'b0));
                    q_exp.push_back(mk(b, 1'b1, ph[0], 1'b1, 1'b1, 1'b0));
                end
                q_exp.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
            end
        end
        q_exp.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q_exp.delete();
        end else begin
            acc = (q_exp.size() == 0) || q_exp[0].done;
            if (q_exp.size() > 0) void'(q_exp.pop_front());
            if (start && acc) begin
                q_exp.delete();
                push_burst(field_mask);
            end
        end
        #1;
        exp_o = (q_exp.size() > 0) ? q_exp[0] : c_idle;
        act_o = {ad_out, ad_oe, cs_n, ad_n, wr_n, busy, done};
        chk("bus_trace", 32'(act_o), 32'(exp_o));

        if (seen_seq != clr_seq) begin
            seen_seq   = clr_seq;
            busy_cnt   = 0;
            done_cnt   = 0;
            cs_low_cnt = 0;
            run        = 0;
            addr_q.delete();
            data_q.delete();
            runs.delete();
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (cs_n === 1'b0) cs_low_cnt++;
        if (wr_n === 1'b0) begin
            if (prev_wr === 1'b1) begin
                if (ad_n === 1'b0) addr_q.push_back(ad_out);
                else data_q.push_back(ad_out);
            end
            run++;
        end else if (prev_wr === 1'b0 && run > 0) begin
            runs.push_back(run);
            run = 0;
        end
        prev_wr = wr_n;
    end

    task automatic clear_mon();
        @(negedge clk);
        clr_seq++;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [8:0] m);
        @(negedge clk);
        field_mask = m;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic load_full();
        v[0] = 8'h59; v[1] = 8'h07; v[2] = 8'h23; v[3] = 8'h31; v[4] = 8'h12;
        v[5] = 8'h17; v[6] = 8'h30; v[7] = 8'h15; v[8] = 8'h01;
    endtask

    initial begin
        addr_tbl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        reset = 1'b1;
        start = 1'b0;
        field_mask = 9'd0;
        for (int i = 0; i < 9; i++) v[i] = 8'h00;
        prev_wr = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ad_out", 32'(ad_out), 32'h00);
        chk("reset_ctrl", 32'({ad_oe, cs_n, ad_n, wr_n, busy, done}), 32'b011100);
        reset = 1'b0;

        // Reset wins over a coincident start.
        load_full();
        @(negedge clk);
        reset = 1'b1; start = 1'b1; field_mask = 9'h1FF;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("reset_vs_start_busy", 32'(busy), 32'd0);
        chk("reset_vs_start_cs", 32'(cs_n), 32'd1);

        // Full burst.
        clear_mon();
        pulse_start(9'h1FF);
        wait_done(300);
        chk("full_busy_cycles", 32'(busy_cnt), 32'd117);
        chk("full_done_once", 32'(done_cnt), 32'd1);
        chk("full_wr_pulses", 32'(runs.size()), 32'd18);
        for (int i = 0; i < runs.size(); i++) chk("full_wr_width", 32'(runs[i]), 32'd4);
        chk("full_addr_count", 32'(addr_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < addr_q.size(); i++) chk("full_addr", 32'(addr_q[i]), 32'(addr_tbl[i]));
        for (int i = 0; i < 9 && i < data_q.size(); i++) chk("full_data", 32'(data_q[i]), 32'(v[i]));

        // Timer fields only.
        clear_mon();
        pulse_start(9'h1C0);
        wait_done(200);
        chk("tim_busy_cycles", 32'(busy_cnt), 32'd39);
        chk("tim_addr_count", 32'(addr_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < addr_q.size(); i++) chk("tim_addr", 32'(addr_q[i]), 32'(8'h41 + 8'(i)));

        // Empty mask: done in the very next cycle, bus untouched.
        clear_mon();
        pulse_start(9'h000);
        chk("empty_done_next", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("empty_busy", 32'(busy_cnt), 32'd0);
        chk("empty_cs_low", 32'(cs_low_cnt), 32'd0);
        chk("empty_done_once", 32'(done_cnt), 32'd1);

        // Snapshot: input change and restart during the first address strobe.
        clear_mon();
        load_full();
        pulse_start(9'h1FF);
        @(negedge clk);
        chk("snap_in_a_stb", 32'(wr_n), 32'd0);
        v[0] = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300);
        chk("snap_seg_data", 32'(data_q.size() > 0 ? data_q[0] : 8'hFF), 32'h59);
        chk("snap_busy_cycles", 32'(busy_cnt), 32'd117);
        chk("snap_done_once", 32'(done_cnt), 32'd1);

        // Reset during the data strobe of the mes field.
        clear_mon();
        load_full();
        pulse_start(9'h1FF);
        begin
            int n;
            n = 0;
            while (!(wr_n === 1'b0 && ad_n === 1'b1 && ad_out === 8'h12) && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("reach_mes_dstb", 32'(n < 300), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_wr_n", 32'(wr_n), 32'd1);
        chk("midrst_cs_n", 32'(cs_n), 32'd1);
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        clear_mon();
        v[0] = 8'h45;
        pulse_start(9'h001);
        wait_done(100);
        chk("restart_busy", 32'(busy_cnt), 32'd13);
        chk("restart_addr", 32'(addr_q.size() > 0 ? addr_q[0] : 8'hFF), 32'h21);
        chk("restart_data", 32'(data_q.size() > 0 ? data_q[0] : 8'hFF), 32'h45);

        // Random traffic: starts while busy, back-to-back starts, stray resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 5) == 0);
            field_mask = ($urandom_range(0, 4) == 0) ? 9'h000 : 9'($urandom);
            for (int i = 0; i < 9; i++) v[i] = 8'($urandom);
            reset      = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (150) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
